multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 16, meaning the program-counter and address width.
REQ-002 SHALL have parameter RESET_PC, default 0, meaning the PC value loaded on reset.
REQ-003 SHALL have port clk  input  1  meaning the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  meaning the reset: asynchronous, active-low.
REQ-005 SHALL have port run  input  1  meaning start/continue execution; sampled only in IDLE.
REQ-006 SHALL have port opcode  input  3  meaning the decoded opcode, valid in DECODE.
REQ-007 SHALL have port target_addr  input  PC_WIDTH  meaning the decoded branch/jump target, valid in DECODE.
REQ-008 SHALL have port alu_zero  input  1  meaning the ALU zero flag, valid in EXECUTE.
REQ-009 SHALL have ports imem_req (output, 1), imem_addr (output, PC_WIDTH) and imem_ack (input, 1), meaning the instruction-memory request/acknowledge handshake.
REQ-010 SHALL have ports dmem_req (output, 1), dmem_we (output, 1) and dmem_ack (input, 1), meaning the data-memory request/acknowledge handshake.
REQ-011 SHALL have outputs ir_load, alu_en and rf_we, each 1 bit, meaning single-cycle strobes for instruction-register capture, ALU execute and register-file write.
REQ-012 SHALL have outputs pc (PC_WIDTH), state (3), halted (1) and instr_count (16), meaning the current PC, the encoded FSM state, the halt indicator and the retired-instruction counter.

Function
REQ-013 SHALL encode the states as IDLE=0, FETCH=1, DECODE=2, EXECUTE=3, MEM=4, WB=5 and HALT=6; code 7 SHALL be unreachable and SHALL fall back to IDLE.
REQ-014 SHALL decode the opcodes as 000 NOP, 001 ADD, 010 SUB, 011 LOAD, 100 STORE, 101 BEQZ (branch if alu_zero), 110 JUMP and 111 HALT.
REQ-015 SHALL transition IDLE->FETCH on a clock edge with run=1, and SHALL remain in IDLE otherwise.
REQ-016 SHALL hold imem_req=1 and imem_addr=pc continuously in FETCH until the first cycle with imem_ack=1, with no timeout.
REQ-017 SHALL, in the FETCH cycle with imem_ack=1, assert ir_load for exactly that cycle, increment pc by 1 (modulo 2^PC_WIDTH, so the maximum address wraps to 0) and go to DECODE.
REQ-018 SHALL, in DECODE, register opcode and target_addr internally and go to EXECUTE, except for HALT, which SHALL go directly to the HALT state.
REQ-019 SHALL assert alu_en for exactly one cycle in EXECUTE.
REQ-020 SHALL, on leaving EXECUTE, go to MEM for LOAD/STORE, to WB for ADD/SUB, and to FETCH (run=1) or IDLE (run=0) for NOP, BEQZ and JUMP.
REQ-021 SHALL load pc with the latched target at the EXECUTE edge for JUMP, and for BEQZ only when alu_zero=1; otherwise pc SHALL be unchanged.
REQ-022 SHALL hold dmem_req=1 in MEM until dmem_ack=1, with dmem_we=1 for STORE and dmem_we=0 for LOAD; dmem_we SHALL be 0 whenever dmem_req=0.
REQ-023 SHALL, on dmem_ack in MEM, go to WB for LOAD and to FETCH/IDLE (per run) for STORE.
REQ-024 SHALL assert rf_we for exactly one cycle in WB, then go to FETCH (run=1) or IDLE (run=0).
REQ-025 SHALL increment instr_count (wrapping at 16 bits) once per instruction on its final state-exit edge; HALT SHALL count once on entry to the HALT state.
REQ-026 SHALL hold halted=1 in HALT, keep all strobes and requests at 0, and leave HALT only via reset.
REQ-027 SHALL ignore an imem_ack or dmem_ack that arrives outside the matching request state.

Reset
REQ-028 SHALL, while rst_n=0 and regardless of clock, force state=IDLE, pc=RESET_PC, instr_count=0, halted=0 and every request and strobe output to 0, including mid-handshake.
REQ-029 SHALL, after rst_n deasserts, change no state until the first rising clk edge with run=1.

Verification
REQ-030 SHALL cover ADD with ack one cycle after imem_req -> states 1,2,3,5,1; rf_we pulses once; pc 0->1; instr_count=1.
REQ-031 SHALL cover LOAD with dmem_ack delayed 3 cycles -> dmem_req high for 4 cycles with dmem_we=0, then WB with rf_we; STORE -> dmem_we=1 and no WB.
REQ-032 SHALL cover BEQZ with target 0x0040: alu_zero=1 -> pc=0x0040; alu_zero=0 -> pc=fetch PC+1; JUMP with target 0x1234 -> pc=0x1234.
REQ-033 SHALL cover a fetch at pc=0xFFFF -> pc wraps to 0x0000; HALT -> halted=1, state=6 persists with run=1 for 20 cycles.
REQ-034 SHALL cover rst_n pulsed low mid-MEM with dmem_req=1 -> outputs drop asynchronously, pc=RESET_PC, instr_count=0.
REQ-035 SHALL cover run=0 during EXECUTE of a NOP -> return to IDLE, with no imem_req asserted until run=1.

Source files
------------

// File: rtl/multicycle_controller.sv
// Multicycle instruction-sequencing controller.
// Steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB and drives the
// instruction/data memory handshakes, datapath strobes, PC and retired-count.
module multicycle_controller #(
  parameter int unsigned       PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [2:0]          opcode,
  input  logic [PC_WIDTH-1:0] target_addr,
  input  logic                alu_zero,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  output logic                dmem_req,
  output logic                dmem_we,
  input  logic                dmem_ack,
  output logic                ir_load,
  output logic                alu_en,
  output logic                rf_we,
  output logic [PC_WIDTH-1:0] pc,
  output logic [2:0]          state,
  output logic                halted,
  output logic [15:0]         instr_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXECUTE = 3'd3,
    S_MEM     = 3'd4,
    S_WB      = 3'd5,
    S_HALT    = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP   = 3'b000,
    OP_ADD   = 3'b001,
    OP_SUB   = 3'b010,
    OP_LOAD  = 3'b011,
    OP_STORE = 3'b100,
    OP_BEQZ  = 3'b101,
    OP_JUMP  = 3'b110,
    OP_HALT  = 3'b111
  } op_t;

  state_t              state_q, state_d;
  op_t                 op_q, op_d;
  logic [PC_WIDTH-1:0] tgt_q, tgt_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]         cnt_q, cnt_d;

  // State, PC, latched decode fields and retired-instruction counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      tgt_q   <= '0;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tgt_q   <= tgt_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, datapath updates and Moore/Mealy strobes.
  // Outputs decode from state so an asynchronous reset drops them at once.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    tgt_d    = tgt_q;
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_load  = 1'b0;
    alu_en   = 1'b0;
    rf_we    = 1'b0;
    halted   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (run) state_d = S_FETCH;
      end
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_load = 1'b1;
          pc_d    = pc_q + PC_WIDTH'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        op_d  = op_t'(opcode);
        tgt_d = target_addr;
        if (op_t'(opcode) == OP_HALT) begin
          cnt_d   = cnt_q + 16'd1;
          state_d = S_HALT;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        alu_en = 1'b1;
        case (op_q)
          OP_LOAD, OP_STORE: state_d = S_MEM;
          OP_ADD, OP_SUB:    state_d = S_WB;
          default: begin
            if (op_q == OP_JUMP || (op_q == OP_BEQZ && alu_zero)) pc_d = tgt_q;
            cnt_d   = cnt_q + 16'd1;
            state_d = run ? S_FETCH : S_IDLE;
          end
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (op_q == OP_STORE);
        if (dmem_ack) begin
          if (op_q == OP_LOAD) begin
            state_d = S_WB;
          end else begin
            cnt_d   = cnt_q + 16'd1;
            state_d = run ? S_FETCH : S_IDLE;
          end
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        cnt_d   = cnt_q + 16'd1;
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign state       = state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed testbench for multicycle_controller.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [2:0]  opcode;
  logic [15:0] target_addr;
  logic        alu_zero;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic        ir_load;
  logic        alu_en;
  logic        rf_we;
  logic [15:0] pc;
  logic [2:0]  state;
  logic        halted;
  logic [15:0] instr_count;

  int total = 0;
  int bad   = 0;

  multicycle_controller #(.PC_WIDTH(16), .RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
    .target_addr(target_addr), .alu_zero(alu_zero),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .ir_load(ir_load), .alu_en(alu_en), .rf_we(rf_we),
    .pc(pc), .state(state), .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; opcode = 3'd0; target_addr = '0;
    alu_zero = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0;
    #2;
    chk("rst_state", 32'(state), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_cnt", 32'(instr_count), 0);
    chk("rst_imem_req", 32'(imem_req), 0);
    chk("rst_halted", 32'(halted), 0);
    #10 rst_n = 1'b1;
    step(); step();
    chk("idle_hold", 32'(state), 0);

    // ADD, imem_ack one cycle after request
    run = 1'b1;
    step();
    chk("add_fetch", 32'(state), 1);
    chk("add_imem_req", 32'(imem_req), 1);
    chk("add_imem_addr", 32'(imem_addr), 0);
    imem_ack = 1'b1; #1;
    chk("add_ir_load", 32'(ir_load), 1);
    step();
    chk("add_decode", 32'(state), 2);
    chk("add_pc", 32'(pc), 1);
    chk("add_ir_load_off", 32'(ir_load), 0);
    imem_ack = 1'b0; opcode = 3'b001;
    step();
    chk("add_exec", 32'(state), 3);
    chk("add_alu_en", 32'(alu_en), 1);
    step();
    chk("add_wb", 32'(state), 5);
    chk("add_rf_we", 32'(rf_we), 1);
    chk("add_alu_en_off", 32'(alu_en), 0);
    step();
    chk("add_refetch", 32'(state), 1);
    chk("add_rf_we_off", 32'(rf_we), 0);
    chk("add_cnt", 32'(instr_count), 1);

    // LOAD with dmem_ack after 3 wait cycles
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0; opcode = 3'b011;
    step();
    step();
    for (int i = 0; i < 4; i++) begin
      chk("load_dmem_req", 32'(dmem_req), 1);
      chk("load_dmem_we", 32'(dmem_we), 0);
      if (i == 3) dmem_ack = 1'b1;
      step();
    end
    dmem_ack = 1'b0;
    chk("load_wb", 32'(state), 5);
    chk("load_rf_we", 32'(rf_we), 1);
    chk("load_dmem_req_off", 32'(dmem_req), 0);
    step();
    chk("load_cnt", 32'(instr_count), 2);
    chk("load_pc", 32'(pc), 2);

    // STORE: write, no WB
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0; opcode = 3'b100;
    step();
    step();
    chk("store_mem", 32'(state), 4);
    chk("store_dmem_we", 32'(dmem_we), 1);
    dmem_ack = 1'b1;
    step();
    dmem_ack = 1'b0;
    chk("store_no_wb", 32'(state), 1);
    chk("store_we_off", 32'(dmem_we), 0);
    chk("store_cnt", 32'(instr_count), 3);

    // BEQZ taken
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0; opcode = 3'b101; target_addr = 16'h0040;
    step();
    alu_zero = 1'b1;
    step();
    alu_zero = 1'b0;
    chk("beqz_t_pc", 32'(pc), 32'h40);
    chk("beqz_t_cnt", 32'(instr_count), 4);

    // BEQZ not taken
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0; opcode = 3'b101; target_addr = 16'h0040;
    step();
    step();
    chk("beqz_nt_pc", 32'(pc), 32'h41);

    // JUMP 0x1234
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0; opcode = 3'b110; target_addr = 16'h1234;
    step();
    step();
    chk("jump_pc", 32'(pc), 32'h1234);
    chk("jump_cnt", 32'(instr_count), 6);

    // JUMP to 0xFFFF, then fetch wraps to 0
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0; opcode = 3'b110; target_addr = 16'hFFFF;
    step();
    step();
    chk("ffff_pc", 32'(pc), 32'hFFFF);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    chk("wrap_pc", 32'(pc), 0);

    // NOP with run dropped during EXECUTE -> IDLE, stray imem_ack ignored
    opcode = 3'b000;
    step();
    run = 1'b0;
    step();
    chk("nop_idle", 32'(state), 0);
    chk("nop_cnt", 32'(instr_count), 8);
    imem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("idle_no_req", 32'(imem_req), 0);
      step();
    end
    chk("idle_stray_pc", 32'(pc), 0);
    chk("idle_stray_state", 32'(state), 0);
    imem_ack = 1'b0;

    // HALT persists with run=1 and acks present
    run = 1'b1;
    step();
    chk("halt_fetch", 32'(state), 1);
    imem_ack = 1'b1;
    step();
    opcode = 3'b111;
    dmem_ack = 1'b1;
    step();
    chk("halt_cnt", 32'(instr_count), 9);
    for (int i = 0; i < 20; i++) begin
      chk("halt_state", 32'(state), 6);
      chk("halt_flag", 32'(halted), 1);
      chk("halt_reqs", 32'({imem_req, dmem_req, ir_load, alu_en, rf_we}), 0);
      step();
    end
    chk("halt_cnt_hold", 32'(instr_count), 9);
    imem_ack = 1'b0; dmem_ack = 1'b0;

    // Asynchronous reset mid-MEM
    rst_n = 1'b0; #2 rst_n = 1'b1;
    step();
    chk("rst2_fetch", 32'(state), 1);
    imem_ack = 1'b1;
    step();
    imem_ack = 1'b0; opcode = 3'b011;
    step();
    step();
    chk("mid_mem_req", 32'(dmem_req), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_dmem_req", 32'(dmem_req), 0);
    chk("arst_state", 32'(state), 0);
    chk("arst_pc", 32'(pc), 0);
    chk("arst_cnt", 32'(instr_count), 0);
    run = 1'b0;
    #1 rst_n = 1'b1;
    step();
    chk("arst_idle_hold", 32'(state), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
